// File: rtl/xc_aesmix_iter.sv
// Iterative AES MixColumns / InvMixColumns: one 32-bit column result built LANES bytes per cycle.
// LANES=4 is combinational and cycle-equivalent to the single-cycle unit.
module xc_aesmix_iter #(
    parameter int LANES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    localparam int STEPS = 4 / LANES;
    localparam int CW    = (STEPS > 2) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("xc_aesmix_iter: LANES must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xt2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xt2(x);
        end
        return p;
    endfunction

    // Output row r weights input byte i by coefficient c[(i - r) mod 4].
    function automatic logic [7:0] lane_byte(input logic [31:0] t, input logic [1:0] row,
                                             input logic en);
        logic [7:0] sum;
        logic [1:0] idx;
        logic [3:0] k;
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i) - row;
            case (idx)
                2'd0:    k = en ? 4'h2 : 4'he;
                2'd1:    k = en ? 4'h3 : 4'hb;
                2'd2:    k = en ? 4'h1 : 4'hd;
                default: k = en ? 4'h1 : 4'h9;
            endcase
            sum = sum ^ gmul(t[8*i +: 8], k);
        end
        return sum;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   acc_q, acc_d;
    logic [31:0]   col;
    logic [31:0]   cur;
    logic [31:0]   acc_ext;
    logic [3:0]    in_grp;
    logic [1:0]    row;
    logic          last;
    logic          unused_bits;

    assign unused_bits = ^{rs1[31:16], rs2[15:0]};

    always_comb begin
        col     = {rs2[31:16], rs1[15:0]};
        cur     = 32'h0;
        in_grp  = 4'h0;
        row     = 2'd0;
        for (int l = 0; l < LANES; l++) begin
            row = 2'(int'(cnt_q) * LANES + l);
            cur[8*row +: 8] = lane_byte(col, row, enc);
            in_grp[row]     = 1'b1;
        end

        last  = (cnt_q == LAST);
        cnt_d = (valid && !last) ? cnt_q + CW'(1) : '0;

        acc_d = acc_q;
        if (valid && !last) begin
            for (int b = 0; b < 3; b++) begin
                if (in_grp[b]) acc_d[8*b +: 8] = cur[8*b +: 8];
            end
        end

        ready   = reset && valid && last;
        acc_ext = {8'h00, acc_q};
        result  = 32'h0;
        if (ready) begin
            for (int b = 0; b < 4; b++) begin
                result[8*b +: 8] = in_grp[b] ? cur[8*b +: 8] : acc_ext[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= 24'h0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_xc_aesmix_iter.sv
// Directed bench for xc_aesmix_iter: LANES=1, 2 and 4 instances share one stimulus stream.
module tb_xc_aesmix_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready1, ready2, ready4;
    logic [31:0] result1, result2, result4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    xc_aesmix_iter #(.LANES(1)) u_dut1 (
        .clock(clock), .reset(reset), .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc),
        .ready(ready1), .result(result1)
    );
    xc_aesmix_iter #(.LANES(2)) u_dut2 (
        .clock(clock), .reset(reset), .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc),
        .ready(ready2), .result(result2)
    );
    xc_aesmix_iter #(.LANES(4)) u_dut4 (
        .clock(clock), .reset(reset), .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc),
        .ready(ready4), .result(result4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Sample one cycle at the falling edge; r1/r2/r4 say which instance should be ready.
    task automatic check_cycle(input string tag, input logic r1, input logic r2, input logic r4,
                               input logic [31:0] exp);
        @(negedge clock);
        chk({tag, " rdy1"}, {31'h0, ready1}, {31'h0, r1});
        chk({tag, " res1"}, result1, r1 ? exp : 32'h0);
        chk({tag, " rdy2"}, {31'h0, ready2}, {31'h0, r2});
        chk({tag, " res2"}, result2, r2 ? exp : 32'h0);
        chk({tag, " rdy4"}, {31'h0, ready4}, {31'h0, r4});
        chk({tag, " res4"}, result4, r4 ? exp : 32'h0);
        @(posedge clock);
        #1;
    endtask

    // Hold valid with one vector for four cycles starting from step 0 on all instances.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input logic [31:0] exp);
        rs1   = a;
        rs2   = b;
        enc   = e;
        valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            check_cycle($sformatf("%s c%0d", tag, c), (c == 4), (c % 2 == 0), 1'b1, exp);
        end
    endtask

    task automatic idle_cycle(input string tag);
        valid = 1'b0;
        check_cycle(tag, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        valid = 1'b1;
        rs1   = 32'h000013db;
        rs2   = 32'h45530000;
        enc   = 1'b1;
        @(posedge clock);
        #1;
        check_cycle("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        check_cycle("reset2", 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        idle_cycle("idle0");

        run_op("enc", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e);
        idle_cycle("idle1");
        run_op("dec", 32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db);
        idle_cycle("idle2");
        run_op("enc2", 32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f);
        idle_cycle("idle3");

        // Back-to-back: valid never drops between the three operations.
        run_op("b2b_a", 32'h00000101, 32'h01010000, 1'b1, 32'h01010101);
        run_op("b2b_b", 32'h00000101, 32'h01010000, 1'b0, 32'h01010101);
        run_op("b2b_c", 32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db);
        idle_cycle("idle4");

        // Abort: one valid cycle, one idle cycle, then a fresh operation.
        rs1   = 32'h000013db;
        rs2   = 32'h45530000;
        enc   = 1'b1;
        valid = 1'b1;
        check_cycle("abort_v", 1'b0, 1'b0, 1'b1, 32'hbca14d8e);
        idle_cycle("abort_gap");
        run_op("abort_new", 32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f);
        idle_cycle("idle5");

        // Reset while the LANES=1 instance is at step 2, valid held throughout.
        rs1   = 32'h00004d8e;
        rs2   = 32'hbca10000;
        enc   = 1'b0;
        valid = 1'b1;
        check_cycle("rst_c1", 1'b0, 1'b0, 1'b1, 32'h455313db);
        check_cycle("rst_c2", 1'b0, 1'b1, 1'b1, 32'h455313db);
        reset = 1'b0;
        check_cycle("rst_lo1", 1'b0, 1'b0, 1'b0, 32'h0);
        check_cycle("rst_lo2", 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        run_op("rst_after", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e);
        idle_cycle("idle6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xc_aesmix_iter.md
# xc_aesmix_iter

Parametrised, iterative AES MixColumns / InvMixColumns unit for the XCrypto AES instruction path. It computes one 32-bit column result from the byte selection {rs2[31:24], rs2[23:16], rs1[15:8], rs1[7:0]}. The result is built LANES bytes per cycle, which trades latency against GF(2^8) multiplier area. With LANES=4 it is cycle-equivalent to the single-cycle xc_aesmix, so it drops in behind the same valid/ready issue interface and its checker.

## Interface
- LANES, 4, output bytes computed per cycle; legal values are 1, 2 and 4. Any other value is an elaboration error. Derived: STEPS = 4/LANES.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low: the block is in reset when reset==0 at a rising clock edge.
- valid  in  1  request valid. Held high until ready.
- rs1  in  32  source 1; only bytes [15:0] are used (t0=rs1[7:0], t1=rs1[15:8]).
- rs2  in  32  source 2; only bytes [31:16] are used (t2=rs2[23:16], t3=rs2[31:24]).
- enc  in  1  1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt).
- ready  out  1  result valid this cycle; a single-cycle pulse per operation.
- result  out  32  {b3,b2,b1,b0}; 0 whenever ready==0.

## Operation
- GF(2^8) arithmetic uses the AES polynomial:
  - xt2(a) = (a<<1) ^ (a[7] ? 8'h1b : 0), truncated to 8 bits.
  - Multiply-by-k is the XOR of xt2 powers selected by the bits of k.
- Encrypt:
  - b0 = 2t0^3t1^t2^t3
  - b1 = t0^2t1^3t2^t3
  - b2 = t0^t1^2t2^3t3
  - b3 = 3t0^t1^t2^2t3
- Decrypt:
  - b0 = e·t0^b·t1^d·t2^9·t3
  - b1 = 9·t0^e·t1^b·t2^d·t3
  - b2 = d·t0^9·t1^e·t2^b·t3
  - b3 = b·t0^d·t1^9·t2^e·t3
- Datapath:
  - LANES byte-lane units. Each lane unit takes a row select (0..3) and enc, and produces one byte.
  - Step k computes bytes k·LANES … k·LANES+LANES-1, lowest byte first.
- State:
  - Step counter cnt, width max(1, log2(STEPS)).
  - Byte accumulator acc, 24 bits; unused when LANES=4.
- Per-cycle rules:
  - valid==0: next cnt = 0; acc holds (don't-care); ready = 0.
  - valid==1, cnt < STEPS-1: the current group is written into acc; next cnt = cnt+1; ready = 0.
  - valid==1, cnt == STEPS-1: ready = 1; result = {current group, acc lower bytes}, formed combinationally; next cnt = 0.
- Caller obligations:
  - rs1, rs2 and enc must stay stable while valid && !ready.
  - Changing them mid-operation yields an undefined result but never deadlocks; the counter still completes.
- Abort: valid falling before ready discards the partial result. The next valid starts at step 0.
- Back-to-back: valid held high through the ready cycle starts a new operation on the following cycle, using the inputs present then.

## Timing
- Reset (reset==0 at the edge): cnt = 0, acc = 0. ready = 0 and result = 0 for as long as reset is low, regardless of valid.
- Reset asserted mid-operation aborts it. After release, the first valid cycle is step 0.
- Latency: ready is asserted in the STEPS-th consecutive cycle of valid, counting the first valid cycle as cycle 1.
  - LANES=4: same cycle, combinational.
  - LANES=2: second cycle.
  - LANES=1: fourth cycle.
- Throughput: one result per STEPS cycles with valid held continuously.
- ready never asserts when valid==0, and never asserts on two consecutive cycles unless LANES=4.
- No combinational path from valid to ready except through the cnt == STEPS-1 compare; result depends combinationally on rs1, rs2 and enc.

## Test plan
- Encrypt vector, all LANES: rs1=0x000013db, rs2=0x45530000, enc=1, valid held → ready after STEPS cycles with result=0xbca14d8e; result=0 in every other cycle.
- Decrypt vector, all LANES: rs1=0x00004d8e, rs2=0xbca10000, enc=0 → result=0x455313db. Also rs1=0x00000af2, rs2=0x5c220000, enc=1 → 0x9d58dc9f.
- Back-to-back, LANES=1: three operations with valid continuously high, each vector changed only after its ready → ready pulses on cycles 4, 8 and 12 with the correct results. Identity input rs1=0x0101, rs2=0x01010000 returns 0x01010101 for both enc=1 and enc=0.
- Abort, LANES=2 and LANES=1: valid high for 1 cycle, then low for 1 cycle, then high with a new vector → no ready during the aborted attempt; the new result arrives STEPS cycles after valid re-rises.
- Reset mid-operation, LANES=1: assert reset (low) at step 2 while valid stays high → ready and result stay 0 during reset; after release, ready arrives exactly 4 cycles later with the correct result.
- Formal equivalence: exhaustive random stimulus against the combinational golden model, with the stable-input assumption applied → assert that result equals the golden result whenever valid && ready, for LANES ∈ {1, 2, 4}.
